// File: rtl/jtframe_ddr_arb.sv
// Two-port arbiter for the shared DDR3 Avalon port. Port 0 has priority; port 1 is starvation-safe.
// Optional status registers are enabled with `define JTFRAME_DDR_ARB_STATUS_EN.
module jtframe_ddr_arb #(
  parameter int unsigned MAXWAIT = 64,
  parameter int unsigned CW      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_rd,
  input  logic        m0_we,
  input  logic [28:0] m0_addr,
  input  logic [7:0]  m0_burstcnt,
  input  logic [63:0] m0_din,
  input  logic [7:0]  m0_be,
  output logic        m0_busy,
  output logic [63:0] m0_dout,
  output logic        m0_dout_ready,
  input  logic        m1_rd,
  input  logic        m1_we,
  input  logic [28:0] m1_addr,
  input  logic [7:0]  m1_burstcnt,
  input  logic [63:0] m1_din,
  input  logic [7:0]  m1_be,
  output logic        m1_busy,
  output logic [63:0] m1_dout,
  output logic        m1_dout_ready,
  output logic        ddram_clk,
  input  logic        ddram_busy,
  output logic [7:0]  ddram_burstcnt,
  output logic [28:0] ddram_addr,
  input  logic [63:0] ddram_dout,
  input  logic        ddram_dout_ready,
  output logic        ddram_rd,
  output logic [63:0] ddram_din,
  output logic [7:0]  ddram_be,
  output logic        ddram_we,
  input  logic [7:0]  st_addr,
  output logic [7:0]  st_dout
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StWr      = 2'd1,
    StRdIssue = 2'd2,
    StRdData  = 2'd3
  } state_e;

  state_e         state_q;
  logic           gnt_q;
  logic [7:0]     beats_q;
  logic [7:0]     blen_q;
  logic [CW-1:0]  wait1_q;

  logic       m0_req, m1_req;
  logic       wait_hit, pick1, pick0, in_idle;
  logic       sel_rd, sel_we, sel_rdy;
  logic       wr_acc, rd_acc, m1_waiting;
  logic [7:0] sel_bc, pick_bc, pick_len;

  assign ddram_clk = clk;
  assign m0_dout   = ddram_dout;
  assign m1_dout   = ddram_dout;

  assign m0_req   = m0_rd | m0_we;
  assign m1_req   = m1_rd | m1_we;
  assign in_idle  = (state_q == StIdle);
  assign wait_hit = 32'(wait1_q) >= MAXWAIT;
  assign pick1    = m1_req && (!m0_req || wait_hit);
  assign pick0    = m0_req && !pick1;
  assign pick_bc  = pick1 ? m1_burstcnt : m0_burstcnt;
  assign pick_len = (pick_bc == 8'd0) ? 8'd1 : pick_bc;

  // Data path follows the latched grant; strobes are qualified by state below.
  assign sel_rd         = gnt_q ? m1_rd : m0_rd;
  assign sel_we         = gnt_q ? m1_we : m0_we;
  assign sel_bc         = gnt_q ? m1_burstcnt : m0_burstcnt;
  assign ddram_burstcnt = (sel_bc == 8'd0) ? 8'd1 : sel_bc;
  assign ddram_addr     = gnt_q ? m1_addr : m0_addr;
  assign ddram_din      = gnt_q ? m1_din : m0_din;
  assign ddram_be       = gnt_q ? m1_be : m0_be;

  assign wr_acc     = (state_q == StWr) && sel_we && !ddram_busy;
  assign rd_acc     = (state_q == StRdIssue) && sel_rd && !ddram_busy;
  // Port 1 is not waiting while it owns the bus.
  assign m1_waiting = m1_req && !(!in_idle && gnt_q);

  always_comb begin
    ddram_rd      = 1'b0;
    ddram_we      = 1'b0;
    m0_busy       = 1'b1;
    m1_busy       = 1'b1;
    sel_rdy       = 1'b0;
    if (!rst) begin
      unique case (state_q)
        StWr: begin
          ddram_we = sel_we;
          if (gnt_q) m1_busy = ddram_busy;
          else       m0_busy = ddram_busy;
        end
        StRdIssue: begin
          ddram_rd = sel_rd;
          if (gnt_q) m1_busy = ddram_busy;
          else       m0_busy = ddram_busy;
          sel_rdy  = rd_acc && ddram_dout_ready;
        end
        StRdData: sel_rdy = ddram_dout_ready;
        default: ;
      endcase
    end
    m0_dout_ready = sel_rdy && !gnt_q;
    m1_dout_ready = sel_rdy && gnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      gnt_q   <= 1'b0;
      beats_q <= 8'd0;
      blen_q  <= 8'd1;
      wait1_q <= '0;
    end else begin
      if (in_idle && pick1) begin
        wait1_q <= '0;
      end else if (m1_waiting && wait1_q != {CW{1'b1}}) begin
        wait1_q <= wait1_q + 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (pick1 || pick0) begin
            gnt_q   <= pick1;
            blen_q  <= pick_len;
            beats_q <= 8'd0;
            state_q <= (pick1 ? m1_we : m0_we) ? StWr : StRdIssue;
          end
        end
        StWr: begin
          if (wr_acc) begin
            beats_q <= beats_q + 8'd1;
            if (beats_q + 8'd1 == blen_q) state_q <= StIdle;
          end
        end
        StRdIssue: begin
          if (rd_acc) begin
            // A beat landing with the accepted read already counts.
            if (ddram_dout_ready) begin
              beats_q <= 8'd1;
              state_q <= (blen_q == 8'd1) ? StIdle : StRdData;
            end else begin
              state_q <= StRdData;
            end
          end
        end
        StRdData: begin
          if (ddram_dout_ready) begin
            beats_q <= beats_q + 8'd1;
            if (beats_q + 8'd1 == blen_q) state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef JTFRAME_DDR_ARB_STATUS_EN
  logic [7:0] cnt0_q, cnt1_q, maxw_q, wait_sat;
  logic [5:0] unused_st_addr;

  assign unused_st_addr = st_addr[7:2];
  assign wait_sat       = (32'(wait1_q) > 32'd255) ? 8'hff : 8'(wait1_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q  <= 8'd0;
      cnt1_q  <= 8'd0;
      maxw_q  <= 8'd0;
      st_dout <= 8'd0;
    end else begin
      if (in_idle && pick0) cnt0_q <= cnt0_q + 8'd1;
      if (in_idle && pick1) cnt1_q <= cnt1_q + 8'd1;
      if (wait_sat > maxw_q) maxw_q <= wait_sat;
      unique case (st_addr[1:0])
        2'd0:    st_dout <= {state_q, gnt_q, m0_req, m1_req, 3'b000};
        2'd1:    st_dout <= cnt0_q;
        2'd2:    st_dout <= cnt1_q;
        default: st_dout <= maxw_q;
      endcase
    end
  end
`else
  logic unused_st_addr;

  assign unused_st_addr = ^st_addr;
  assign st_dout        = 8'd0;
`endif

endmodule
